// File: rtl/zigzag_scan.sv
// 8x8 coefficient reorder buffer: captures one block written at (u,v) addresses,
// then streams it out in JPEG zig-zag order over a valid/ready handshake.
module zigzag_scan #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [2:0]        wr_u,
  input  logic [2:0]        wr_v,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [5:0]        out_idx,
  output logic              out_last,
  output logic              overrun
);

  // state   | meaning
  // S_FILL  | accepting raster writes into the buffer
  // S_DRAIN | streaming buffer out in zig-zag order
  localparam logic S_FILL  = 1'b0;
  localparam logic S_DRAIN = 1'b1;

  // Raster address (8*u+v) visited at each zig-zag position k.
  localparam logic [5:0] ZZ_ADDR [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic              r_state;
  logic [5:0]        r_k;
  logic              r_overrun;
  logic [DATA_W-1:0] r_buf [64];

  logic w_fill;
  logic w_wr_ok;
  logic w_hs;

  assign w_fill  = (r_state == S_FILL);
  assign w_wr_ok = wr_en & w_fill & ~flush;
  assign w_hs    = ~w_fill & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FILL;
      r_k       <= 6'd0;
      r_overrun <= 1'b0;
    end else if (flush) begin
      r_state   <= S_FILL;
      r_k       <= 6'd0;
      r_overrun <= 1'b0;
    end else begin
      if (wr_en && !w_fill)
        r_overrun <= 1'b1;
      case (r_state)
        S_FILL: begin
          if (wr_en && wr_last) begin
            r_state <= S_DRAIN;
            r_k     <= 6'd0;
          end
        end
        default: begin
          if (w_hs) begin
            if (r_k == 6'd63) begin
              r_state <= S_FILL;
              r_k     <= 6'd0;
            end else begin
              r_k <= r_k + 6'd1;
            end
          end
        end
      endcase
    end
  end

  // Buffer is only cleared by reset; flush keeps prior contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++)
        r_buf[i] <= '0;
    end else if (w_wr_ok) begin
      r_buf[{wr_u, wr_v}] <= wr_data;
    end
  end

  assign wr_ready  = w_fill;
  assign out_valid = ~w_fill;
  assign out_data  = r_buf[ZZ_ADDR[r_k]];
  assign out_idx   = r_k;
  assign out_last  = ~w_fill & (r_k == 6'd63);
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_zigzag_scan.sv
// Directed bench for zigzag_scan: a reference buffer model feeds a queue of expected
// zig-zag outputs, which are popped and compared on each output handshake.
module tb_zigzag_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_u = 3'd0;
  logic [2:0]  wr_v = 3'd0;
  logic [11:0] wr_data = 12'd0;
  logic        wr_last = 1'b0;
  logic        wr_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_data;
  logic [5:0]  out_idx;
  logic        out_last;
  logic        overrun;

  zigzag_scan #(.DATA_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_en(wr_en), .wr_u(wr_u), .wr_v(wr_v), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err = 0;
  logic [11:0] mdl [64];
  int          zz_tb [64];
  logic [11:0] exp_q [$];
  logic        exp_ovr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent diagonal walk producing the raster address for each k.
  task automatic build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int u = hi; u >= lo; u--) begin zz_tb[k] = u * 8 + (s - u); k++; end
      end else begin
        for (int u = lo; u <= hi; u++) begin zz_tb[k] = u * 8 + (s - u); k++; end
      end
    end
  endtask

  task automatic wr(input int u, input int v, input logic [11:0] d, input bit last);
    chk("wr_ready_fill", wr_ready, 1);
    wr_en = 1'b1; wr_u = 3'(u); wr_v = 3'(v); wr_data = d; wr_last = last;
    @(negedge clk);
    wr_en = 1'b0; wr_last = 1'b0;
    mdl[u * 8 + v] = d;
    if (last)
      for (int k = 0; k < 64; k++) exp_q.push_back(mdl[zz_tb[k]]);
  endtask

  task automatic wr_raster();
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++)
        wr(u, v, 12'(8 * u + v), (u == 7) && (v == 7));
  endtask

  // Negative *_k arguments disable the corresponding event.
  task automatic drain(input bit rnd, input int pulse_k, input int flush_k, input int rst_k);
    int k = 0;
    int cyc = 0;
    bit held = 0;
    bit pulsed = 0;
    logic [11:0] hd = '0;
    logic [5:0]  hi = '0;
    logic [11:0] e;
    while (k < 64 && cyc < 1000) begin
      if (held) begin
        chk("stall_data", out_data, hd);
        chk("stall_idx", out_idx, hi);
      end
      chk("out_valid", out_valid, 1);
      chk("wr_ready_drain", wr_ready, 0);
      chk("out_idx", out_idx, k);
      chk("out_last", out_last, k == 63);
      chk("overrun", overrun, exp_ovr);
      if (k == rst_k) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 64; i++) mdl[i] = '0;
        exp_ovr = 1'b0;
        out_ready = 1'b0;
        return;
      end
      if (k == flush_k) begin
        flush = 1'b1; out_ready = 1'b1;
        wr_en = 1'b1; wr_u = 3'd0; wr_v = 3'd0; wr_data = 12'hABC; wr_last = 1'b1;
        @(negedge clk);
        flush = 1'b0; wr_en = 1'b0; wr_last = 1'b0; out_ready = 1'b0;
        exp_ovr = 1'b0;
        chk("flush_wr_ready", wr_ready, 1);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_overrun", overrun, 0);
        chk("flush_out_idx", out_idx, 0);
        exp_q.delete();
        return;
      end
      if (k == pulse_k && !pulsed) begin
        wr_en = 1'b1; wr_u = 3'd3; wr_v = 3'd3; wr_data = 12'hFFF; wr_last = 1'b1;
        pulsed = 1;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready) begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e);
        k++;
        held = 0;
      end else begin
        held = 1; hd = out_data; hi = out_idx;
      end
      @(negedge clk);
      cyc++;
      if (wr_en) exp_ovr = 1'b1;
      wr_en = 1'b0; wr_last = 1'b0;
    end
    chk("drain_count", k, 64);
    out_ready = 1'b0;
    chk("post_out_valid", out_valid, 0);
    chk("post_wr_ready", wr_ready, 1);
    chk("post_overrun", overrun, exp_ovr);
  endtask

  initial begin
    build_zz();
    for (int i = 0; i < 64; i++) mdl[i] = '0;
    #12;
    chk("reset_wr_ready", wr_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // raster block, free-running drain
    wr_raster();
    drain(0, -1, -1, -1);
    // same block, random back-pressure
    wr_raster();
    drain(1, -1, -1, -1);
    // write attempt during drain sets sticky overrun
    wr_raster();
    drain(1, 10, -1, -1);
    chk("overrun_in_fill", overrun, 1);
    // second block touches only (7,7)
    wr(7, 7, 12'h5A5, 1);
    chk("overrun_still", overrun, 1);
    drain(0, -1, -1, -1);
    // flush mid-drain, then a fresh block drains from k=0
    wr(7, 7, 12'h321, 1);
    drain(0, -1, 20, -1);
    wr(7, 7, 12'h123, 1);
    drain(1, -1, -1, -1);
    // async reset mid-drain, then an untouched block reads back as zeros
    wr(0, 5, 12'h777, 1);
    drain(0, -1, -1, 30);
    @(negedge clk);
    wr(7, 7, 12'h000, 1);
    drain(0, -1, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
